// File: rtl/param_mdu_pkg.sv
// Shared op codes and state encoding for the multiply/divide unit.
package param_mdu_pkg;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;

    typedef enum logic {
        StIdle,
        StBusy
    } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO result generation for multiply and divide operations.
module mdu_arith
    import param_mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi_cur,
    input  logic [WIDTH-1:0] lo_cur,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   safe_b, abs_a, abs_b;
    logic [WIDTH-1:0]   qu, ru, qs_mag, rs_mag, qs, rs;
    logic               div_zero;

    assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Divisor forced to 1 on zero so the dividers never see 0; result is discarded anyway.
    assign div_zero = (b == '0);
    assign safe_b   = div_zero ? WIDTH'(1) : b;

    assign qu = a / safe_b;
    assign ru = a % safe_b;

    assign abs_a  = a[WIDTH-1] ? -a : a;
    assign abs_b  = b[WIDTH-1] ? -b : safe_b;
    assign qs_mag = abs_a / abs_b;
    assign rs_mag = abs_a % abs_b;

    // MIN_INT / -1 wraps the negated magnitude back to MIN_INT with remainder 0.
    assign qs = (a[WIDTH-1] ^ b[WIDTH-1]) ? -qs_mag : qs_mag;
    assign rs = a[WIDTH-1] ? -rs_mag : rs_mag;

    always_comb begin
        res_hi = hi_cur;
        res_lo = lo_cur;
        case (op)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_DIV: begin
                if (!div_zero) begin
                    res_hi = rs;
                    res_lo = qs;
                end
            end
            MDU_DIVU: begin
                if (!div_zero) begin
                    res_hi = ru;
                    res_lo = qu;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/param_mdu.sv
// Multi-cycle multiply/divide unit: HI/LO registers, busy countdown and done pulse.
module param_mdu
    import param_mdu_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] pend_hi_q, pend_lo_q;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             is_mul, is_div;

    assign is_mul = (op == MDU_MULT) || (op == MDU_MULTU);
    assign is_div = (op == MDU_DIV) || (op == MDU_DIVU);

    mdu_arith #(
        .WIDTH(WIDTH)
    ) u_arith (
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_cur(hi),
        .lo_cur(lo),
        .res_hi(res_hi),
        .res_lo(res_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            hi        <= '0;
            lo        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (is_mul || is_div) begin
                            pend_hi_q <= res_hi;
                            pend_lo_q <= res_lo;
                            cnt_q     <= is_mul ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
                            busy      <= 1'b1;
                            state_q   <= StBusy;
                        end else if (op == MDU_MTHI) begin
                            hi <= a;
                        end else if (op == MDU_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                StBusy: begin
                    // Starts are ignored here; upstream is stalled while busy.
                    if (cnt_q == CNT_W'(1)) begin
                        hi      <= pend_hi_q;
                        lo      <= pend_lo_q;
                        cnt_q   <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/param_mdu.md
Name: param_mdu

Overview:
Parametrised multi-cycle multiply/divide unit for the EX stage of the pipelined MIPS-subset CPU.
- Accepts one operation per start pulse and models fixed multiply/divide latencies with a countdown.
- Exposes architectural HI/LO and a busy flag that drives the hazard unit's stall logic.
- Generalises data width and latencies; adds move-to-HI/LO, a done pulse, and defined divide-by-zero and overflow results.

Parameters:
WIDTH, 32, operand and HI/LO width in bits.
MULT_LAT, 5, busy cycles for MULT/MULTU (must be >= 1).
DIV_LAT, 10, busy cycles for DIV/DIVU (must be >= 1).
CNT_W, 8, countdown register width (must hold max(MULT_LAT, DIV_LAT)).

Ports:
clk  input  1  clock, all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  launch the operation on op; sampled each rising edge.
op  input  3  operation code (package constants).
a  input  WIDTH  operand rs (dividend / multiplicand / MTHI-MTLO data).
b  input  WIDTH  operand rt (divisor / multiplier).
hi  output  WIDTH  architectural HI register.
lo  output  WIDTH  architectural LO register.
busy  output  1  registered; high while a multiply or divide is in flight.
done  output  1  registered one-cycle pulse when HI/LO receive a multiply or divide result.

Behaviour:
- Reset (synchronous): hi=0, lo=0, busy=0, done=0, countdown=0, pending result=0.
- Reset mid-operation aborts the operation. HI/LO are zeroed, not loaded with the result.
- Idle (busy=0), start=1, op=MULT/MULTU/DIV/DIVU:
  - The operation is accepted at that edge.
  - The full-width result is computed from a and b and latched into a pending HI/LO pair.
  - countdown loads LAT; busy=1 from the next cycle.
- Busy:
  - countdown decrements each edge.
  - busy stays high for exactly LAT cycles.
  - hi/lo hold their old values throughout.
  - When countdown reaches 1, the next edge copies pending to hi/lo, sets busy=0 and pulses done=1 for one cycle.
- Idle, start=1, op=MTHI: hi<=a at that edge, lo unchanged, no busy, no done. MTLO is the same with lo<=a.
- start while busy=1: ignored entirely, including MTHI/MTLO. The pipeline stalls upstream, so this is a protocol error.
- start with op=NONE or an undefined code: no effect.
- Back-to-back: a start sampled at the same edge that ends busy is ignored, because busy is still 1. A new operation is accepted at the following edge.
- MULT: signed 2*WIDTH product; hi=upper WIDTH bits, lo=lower WIDTH bits.
- MULTU: the same product, computed unsigned.
- DIV (signed):
  - lo=quotient truncated toward zero; hi=remainder with the dividend's sign.
  - Overflow case a=MIN_INT, b=-1: lo=MIN_INT, hi=0.
- DIVU: unsigned quotient to lo, remainder to hi.
- Divide by zero (DIV or DIVU, b=0): full DIV_LAT busy period, done pulses, hi/lo retain their prior values.
- done is 0 in every cycle other than the completion cycle.

Decomposition:
- Shared package (constants header) holds the op codes: MDU_NONE=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6.
- Decode in ID selects these codes.
- One sub-module, mdu_arith: purely combinational result generation (signed/unsigned product, quotient/remainder, div-zero and overflow handling) producing the pending HI/LO.
- The top level holds the countdown FSM (IDLE/BUSY) and the HI/LO registers.

Test Plan:
- Reset, then MULT a=0xFFFFFFFF b=0x00000002 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulses once.
- MULTU with the same operands -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7) b=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU a=5 b=0 after MTHI 0x1234 / MTLO 0x5678 -> busy 10 cycles, done, hi=0x1234, lo=0x5678 unchanged.
- MULT in flight, with DIV start and MTHI start asserted at cycle 2 -> both ignored; MULT result lands at cycle 5; a DIV started the cycle after done is accepted.
- DIVU 100/7 with reset asserted at the 4th busy cycle -> next cycle busy=0, hi=lo=0, no done pulse.
